// File: rtl/axi3_mem_bridge.sv
// AXI3 master bridge: NUM_RD round-robin read clients share AR/R, one write client drives AW/W/B.
// Build macro AXI_BRIDGE_PERF_EN adds read/write burst and AR stall counters.
module axi3_mem_bridge #(
    parameter int NUM_RD = 3,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*8-1:0]      rd_len,
    input  logic [NUM_RD*3-1:0]      rd_size,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic                     rd_err,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [7:0]               wr_len,
    input  logic [2:0]               wr_size,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [STRB_W-1:0]        wr_strb,
    output logic                     wr_beat,
    output logic                     wr_done,
    output logic                     wr_err,
    output logic [ID_W-1:0]          arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_W-1:0]          rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [ID_W-1:0]          awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ID_W-1:0]          wid,
    output logic [DATA_W-1:0]        wdata,
    output logic [STRB_W-1:0]        wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [ID_W-1:0]          bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
`ifdef AXI_BRIDGE_PERF_EN
    ,
    output logic [31:0]              perf_rd_cnt,
    output logic [31:0]              perf_wr_cnt,
    output logic [31:0]              perf_rd_stall
`endif
);
    localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;

    rd_state_t          rd_state_r;
    wr_state_t          wr_state_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rd_owner_r;
    logic [PTR_W-1:0]   pick_s;
    logic               pick_found_s;
    logic [NUM_RD-1:0]  owner_oh_s;
    logic [7:0]         wr_cnt_r;
    logic               unused_s;

    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    // Single outstanding transfer per direction, so response IDs carry no information.
    assign unused_s = ^{rid, rresp[0], bid, bresp[0]};

    // Round-robin pick: first requesting client at or after the pointer.
    always_comb begin
        int j;
        j            = 0;
        pick_s       = '0;
        pick_found_s = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            j = int'(rr_ptr_r) + k;
            if (j >= NUM_RD) begin
                j = j - NUM_RD;
            end else begin
                j = j;
            end
            if (!pick_found_s && rd_req[PTR_W'(j)]) begin
                pick_found_s = 1'b1;
                pick_s       = PTR_W'(j);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign owner_oh_s = NUM_RD'(1) << rd_owner_r;
    assign rd_gnt     = (arvalid && arready) ? owner_oh_s : '0;
    assign rd_valid   = (rready && rvalid) ? owner_oh_s : '0;
    assign rd_data    = rready ? rdata : '0;
    assign rd_last    = rready && rlast;
    assign rd_err     = rready && rvalid && rresp[1];

    // Read FSM: latch the winner's request, hold AR until accepted, then stream R beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_r <= R_IDLE;
            rr_ptr_r   <= '0;
            rd_owner_r <= '0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arid       <= '0;
            arlen      <= '0;
            arsize     <= '0;
            rready     <= 1'b0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (pick_found_s) begin
                        rd_owner_r <= pick_s;
                        araddr     <= rd_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                        arlen      <= rd_len[int'(pick_s)*8 +: 8];
                        arsize     <= rd_size[int'(pick_s)*3 +: 3];
                        arid       <= ID_W'(pick_s);
                        arvalid    <= 1'b1;
                        rd_state_r <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arready) begin
                        arvalid    <= 1'b0;
                        rready     <= 1'b1;
                        rr_ptr_r   <= (rd_owner_r == PTR_W'(NUM_RD - 1)) ? '0 : rd_owner_r + PTR_W'(1);
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready     <= 1'b0;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    arvalid    <= 1'b0;
                    rready     <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign wid     = awid;
    assign wdata   = wvalid ? wr_data : '0;
    assign wstrb   = wvalid ? wr_strb : '0;
    assign wlast   = wvalid && (wr_cnt_r == awlen);
    assign wr_beat = wvalid && wready;
    assign wr_done = bready && bvalid;
    assign wr_err  = wr_done && bresp[1];

    // Write FSM: AW first, then W beats counted against the latched length, then B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_r <= W_IDLE;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            awid       <= '0;
            awlen      <= '0;
            awsize     <= '0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            wr_cnt_r   <= 8'd0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (wr_req) begin
                        awaddr     <= wr_addr;
                        awlen      <= wr_len;
                        awsize     <= wr_size;
                        awid       <= ID_W'(NUM_RD);
                        awvalid    <= 1'b1;
                        wr_state_r <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (awready) begin
                        awvalid    <= 1'b0;
                        wvalid     <= 1'b1;
                        wr_cnt_r   <= 8'd0;
                        wr_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (wr_cnt_r == awlen) begin
                            wvalid     <= 1'b0;
                            bready     <= 1'b1;
                            wr_state_r <= W_RESP;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    awvalid    <= 1'b0;
                    wvalid     <= 1'b0;
                    bready     <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_BRIDGE_PERF_EN
    // Performance counters: completed bursts per direction and AR cycles spent waiting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            perf_rd_cnt   <= 32'd0;
            perf_wr_cnt   <= 32'd0;
            perf_rd_stall <= 32'd0;
        end else begin
            if (rd_state_r == R_DATA && rvalid && rlast) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if (wr_state_r == W_RESP && bvalid) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            if (rd_state_r == R_ADDR && !arready) begin
                perf_rd_stall <= perf_rd_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi3_mem_bridge.sv
// Directed bench for axi3_mem_bridge: table of read arbitration vectors plus write, overlap and reset sequences.
module tb_axi3_mem_bridge;
    localparam int NUM_RD = 3;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct {
        logic [2:0] req;
        logic [7:0] len;
        int         ar_delay;
        bit         err;
        int         exp_owner;
    } rd_vec_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*8-1:0]      rd_len;
    logic [NUM_RD*3-1:0]      rd_size;
    logic [NUM_RD-1:0]        rd_gnt, rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_last, rd_err;
    logic                     wr_req;
    logic [ADDR_W-1:0]        wr_addr;
    logic [7:0]               wr_len;
    logic [2:0]               wr_size;
    logic [DATA_W-1:0]        wr_data;
    logic [STRB_W-1:0]        wr_strb;
    logic                     wr_beat, wr_done, wr_err;
    logic [ID_W-1:0]          arid, rid, awid, wid, bid;
    logic [ADDR_W-1:0]        araddr, awaddr;
    logic [7:0]               arlen, awlen;
    logic [2:0]               arsize, awsize, arprot, awprot;
    logic [1:0]               arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]               arcache, awcache;
    logic                     arvalid, arready, rlast, rvalid, rready;
    logic                     awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]        rdata, wdata;
    logic [STRB_W-1:0]        wstrb;
`ifdef AXI_BRIDGE_PERF_EN
    logic [31:0]              perf_rd_cnt, perf_wr_cnt, perf_rd_stall;
`endif

    int checks = 0;
    int failures = 0;
    logic [ADDR_W-1:0] addr_tbl [NUM_RD];
    rd_vec_t tbl [11];
    rd_vec_t post [2];

    axi3_mem_bridge #(.NUM_RD(NUM_RD), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_beat(wr_beat), .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BRIDGE_PERF_EN
        , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_rd_stall(perf_rd_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_read(input rd_vec_t v);
        logic [NUM_RD-1:0] oh;
        logic [DATA_W-1:0] exp_data;
        int blen;
        oh   = NUM_RD'(1) << v.exp_owner;
        blen = int'(v.len ^ 8'(v.exp_owner));
        for (int c = 0; c < NUM_RD; c++) begin
            rd_len[c*8 +: 8]  = v.len ^ 8'(c);
            rd_size[c*3 +: 3] = 3'(c + 1);
        end
        rd_req = v.req;
        @(posedge aclk); #1;
        chk("arvalid", arvalid, 1);
        chk("arid", arid, v.exp_owner);
        chk("araddr", araddr, addr_tbl[v.exp_owner]);
        chk("arlen", arlen, blen);
        chk("arsize_burst", {arsize, arburst}, {3'(v.exp_owner + 1), 2'b01});
        for (int i = 0; i < v.ar_delay; i++) begin
            @(posedge aclk); #1;
        end
        chk("ar_hold", {arvalid, araddr}, {1'b1, addr_tbl[v.exp_owner]});
        arready = 1'b1;
        @(negedge aclk);
        chk("rd_gnt", rd_gnt, oh);
        @(posedge aclk); #1;
        arready = 1'b0;
        chk("rready_on", {rready, arvalid, rd_gnt}, {1'b1, 1'b0, 3'b000});
        for (int b = 0; b <= blen; b++) begin
            if (b == 1) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                @(negedge aclk);
                chk("rd_gap", rd_valid, 0);
                @(posedge aclk); #1;
            end
            exp_data = 32'hD000_0000 | (32'(v.exp_owner) << 8) | 32'(b);
            rvalid = 1'b1;
            rdata  = exp_data;
            rlast  = (b == blen);
            rresp  = (v.err && b == blen) ? 2'b10 : 2'b00;
            if (b == blen) rd_req = '0;
            @(negedge aclk);
            chk("rd_valid", rd_valid, oh);
            chk("rd_data", rd_data, exp_data);
            chk("rd_last_err", {rd_last, rd_err}, {(b == blen), (v.err && b == blen)});
            @(posedge aclk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("rready_off", rready, 0);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                             input int aw_delay, input logic [1:0] resp);
        int b;
        int cyc;
        wr_addr = addr;
        wr_len  = len;
        wr_size = 3'd2;
        wr_data = 32'hA500_0000;
        wr_strb = 4'hF;
        wr_req  = 1'b1;
        @(posedge aclk); #1;
        chk("awvalid", {awvalid, wvalid}, 2'b10);
        chk("awid", awid, NUM_RD);
        chk("awaddr", awaddr, addr);
        chk("awlen", awlen, len);
        chk("awsize_burst", {awsize, awburst}, {3'd2, 2'b01});
        for (int i = 0; i < aw_delay; i++) begin
            @(posedge aclk); #1;
        end
        chk("aw_hold", {awvalid, awaddr, wvalid}, {1'b1, addr, 1'b0});
        awready = 1'b1;
        @(posedge aclk); #1;
        awready = 1'b0;
        b   = 0;
        cyc = 0;
        while (b <= int'(len)) begin
            wready = (toggle && (cyc % 2 != 0)) ? 1'b0 : 1'b1;
            @(negedge aclk);
            chk("wvalid", {wvalid, awvalid, wid}, {1'b1, 1'b0, 4'(NUM_RD)});
            chk("wdata", {wdata, wstrb}, {32'hA500_0000 | 32'(b), 4'hF ^ 4'(b)});
            chk("wlast", wlast, (b == int'(len)));
            chk("wr_beat", wr_beat, wready);
            @(posedge aclk); #1;
            if (wready) begin
                b++;
                wr_data = 32'hA500_0000 | 32'(b);
                wr_strb = 4'hF ^ 4'(b);
            end
            cyc++;
        end
        wready = 1'b0;
        chk("bready", {bready, wvalid}, 2'b10);
        @(negedge aclk);
        chk("wr_done_early", wr_done, 0);
        @(posedge aclk); #1;
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge aclk);
        chk("wr_done", {wr_done, wr_err}, {1'b1, resp[1]});
        @(posedge aclk); #1;
        bvalid = 1'b0;
        bresp  = 2'b00;
        wr_req = 1'b0;
        chk("bready_off", bready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tbl[0] = 32'h1FC0_0000;
        addr_tbl[1] = 32'h0000_2000;
        addr_tbl[2] = 32'h8000_0040;
        tbl[0]  = '{3'b001, 8'd3, 0, 1'b0, 0};
        tbl[1]  = '{3'b010, 8'd1, 1, 1'b0, 1};
        tbl[2]  = '{3'b100, 8'd2, 0, 1'b1, 2};
        tbl[3]  = '{3'b111, 8'd1, 2, 1'b0, 0};
        tbl[4]  = '{3'b111, 8'd0, 0, 1'b1, 1};
        tbl[5]  = '{3'b111, 8'd2, 1, 1'b0, 2};
        tbl[6]  = '{3'b101, 8'd0, 0, 1'b0, 0};
        tbl[7]  = '{3'b101, 8'd1, 0, 1'b0, 2};
        tbl[8]  = '{3'b010, 8'd0, 3, 1'b0, 1};
        tbl[9]  = '{3'b001, 8'd0, 0, 1'b1, 0};
        tbl[10] = '{3'b110, 8'd2, 0, 1'b0, 1};
        post[0] = '{3'b111, 8'd1, 2, 1'b0, 0};
        post[1] = '{3'b111, 8'd0, 3, 1'b0, 1};

        rd_req = '0; rd_len = '0; rd_size = '0;
        rd_addr = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_size = '0; wr_data = '0; wr_strb = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b00000);
        chk("rst_regs", {araddr, awaddr, arid, awid, arlen, awlen}, 88'h0);
        chk("rst_consts", {arburst, arlock, arcache, arprot, awburst, awlock, awcache, awprot},
            {2'b01, 2'b00, 4'h0, 3'h0, 2'b01, 2'b00, 4'h0, 3'h0});
        aresetn = 1'b1;
        @(posedge aclk); #1;

        for (int i = 0; i < 11; i++) run_read(tbl[i]);

        run_write(32'h8000_0010, 8'd1, 1'b1, 0, 2'b10);
        run_write(32'h0000_0100, 8'd0, 1'b0, 1, 2'b00);
        run_write(32'h0000_4000, 8'd255, 1'b0, 0, 2'b00);

        fork
            run_read('{3'b100, 8'd1, 5, 1'b0, 2});
            run_write(32'h0000_0800, 8'd2, 1'b0, 5, 2'b00);
        join

        // Abandon a 4-beat read from client 1 during its second beat.
        rd_len = {8'd3, 8'd3, 8'd3};
        rd_req = 3'b010;
        @(posedge aclk); #1;
        arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0;
        rd_req  = '0;
        rvalid  = 1'b1;
        rdata   = 32'h1111_0000;
        @(posedge aclk); #1;
        rdata = 32'h1111_0001;
        @(negedge aclk);
        chk("rst_pre_valid", rd_valid, 3'b010);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_valid", {rd_valid, rready, arvalid, rd_last}, 6'b000000);
        chk("rst_mid_regs", {araddr, arid, arlen, rd_data}, 76'h0);
        rvalid = 1'b0;
        rdata  = '0;
        @(posedge aclk); #1;
        aresetn = 1'b1;

        run_read(post[0]);
        run_read(post[1]);
        run_write(32'h0000_0200, 8'd0, 1'b0, 0, 2'b00);
`ifdef AXI_BRIDGE_PERF_EN
        chk("perf_rd_cnt", perf_rd_cnt, 2);
        chk("perf_wr_cnt", perf_wr_cnt, 1);
        chk("perf_rd_stall", perf_rd_stall, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
